// File: rtl/st7735_pkg.sv
// Shared definitions for the ST7735 write-protocol receiver: opcodes,
// decoder states and default panel geometry.
package st7735_pkg;

  localparam int DEF_WIDTH  = 128;
  localparam int DEF_HEIGHT = 160;

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_RASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET_P,
    ST_RASET_P,
    ST_RAMWR_HI,
    ST_RAMWR_LO,
    ST_IGNORE
  } dec_state_e;

endpackage

// File: rtl/st7735_spi_receiver_if.sv
// Bus bundle for the ST7735 receiver: the 4-wire serial input side and the
// decoded command/pixel output side.
// Optional frame counter ports exist only when ST7735_RX_FRAME_CNT_EN is defined.
interface st7735_spi_receiver_if;
  logic        cs;
  logic        mosi;
  logic        dc;
  logic        lcd_clk;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        pixel_valid;
  logic [7:0]  pixel_x;
  logic [7:0]  pixel_y;
  logic [15:0] pixel_data;
  logic        display_on;
  logic        error;
`ifdef ST7735_RX_FRAME_CNT_EN
  logic        frame_done;
  logic [15:0] frame_count;
`endif

  modport slave (
    input  cs, mosi, dc, lcd_clk,
`ifdef ST7735_RX_FRAME_CNT_EN
    output frame_done, frame_count,
`endif
    output cmd_valid, cmd_byte, pixel_valid, pixel_x, pixel_y, pixel_data,
           display_on, error
  );

  modport master (
    output cs, mosi, dc, lcd_clk,
`ifdef ST7735_RX_FRAME_CNT_EN
    input  frame_done, frame_count,
`endif
    input  cmd_valid, cmd_byte, pixel_valid, pixel_x, pixel_y, pixel_data,
           display_on, error
  );
endinterface

// File: rtl/st7735_spi_receiver_spi_byte_rx.sv
// Serial byte assembler: synchronizes the four bus pins into the system
// clock domain, shifts MOSI on LCD_CLK rising edges while selected, and
// flags bytes cut short by CS going high.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cs_i,
  input  logic       mosi_i,
  input  logic       dc_i,
  input  logic       lcd_clk_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       dc_o,
  output logic       error_o
);

  // bit order in each stage: {cs, mosi, dc, lcd_clk}
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic       cs_s, mosi_s, dc_s, clk_s;
  logic       clk_prev_q, cs_prev_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       byte_valid_q, dc_q, error_q;
  logic [7:0] byte_q;
  logic       shift_en;

  assign {cs_s, mosi_s, dc_s, clk_s} = sync_q[SYNC_STAGES-1];

  // A rising clock is still accepted in the cycle CS rises so that a byte
  // whose last edge coincides with deselect completes cleanly.
  assign shift_en = clk_s & ~clk_prev_q & ~(cs_s & cs_prev_q);

  // Multi-stage synchronizer; CS idles high out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= {SYNC_STAGES{4'b1000}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], {cs_i, mosi_i, dc_i, lcd_clk_i}};
  end

  // Edge detect, shifter, bit counter and sticky abort flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_prev_q   <= 1'b0;
      cs_prev_q    <= 1'b1;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'd0;
      dc_q         <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      clk_prev_q   <= clk_s;
      cs_prev_q    <= cs_s;
      byte_valid_q <= 1'b0;
      if (shift_en) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid_q <= 1'b1;
          byte_q       <= {shift_q, mosi_s};
          dc_q         <= dc_s;
        end
      end else if (cs_s) begin
        if (bit_cnt_q != 3'd0) error_q <= 1'b1;
        bit_cnt_q <= 3'd0;
      end
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;
  assign dc_o         = dc_q;
  assign error_o      = error_q;

endmodule

// File: rtl/st7735_spi_receiver.sv
// ST7735 write-protocol decoder: turns received command/data bytes into
// window updates, display on/off state and addressed RGB565 pixel writes.
// Optional: ST7735_RX_FRAME_CNT_EN adds FRAME_DONE / FRAME_COUNT outputs.
//
//   state        | meaning
//   ST_IDLE      | waiting for a command; stray data bytes dropped
//   ST_CASET_P   | collecting 4 column-window parameter bytes
//   ST_RASET_P   | collecting 4 row-window parameter bytes
//   ST_RAMWR_HI  | next data byte is a pixel high byte
//   ST_RAMWR_LO  | next data byte completes a pixel
//   ST_IGNORE    | unsupported command; its data bytes dropped
module st7735_spi_receiver
  import st7735_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    SYSTEM_CLK,
  input  logic                    RESET,
  st7735_spi_receiver_if.slave    bus
);

  localparam logic [7:0] XE_DEF = 8'(WIDTH - 1);
  localparam logic [7:0] YE_DEF = 8'(HEIGHT - 1);
  localparam logic [8:0] W_LIM  = 9'(WIDTH);
  localparam logic [8:0] H_LIM  = 9'(HEIGHT);

  logic       rx_valid, rx_dc, rx_error;
  logic [7:0] rx_byte;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk_i        (SYSTEM_CLK),
    .rst_i        (RESET),
    .cs_i         (bus.cs),
    .mosi_i       (bus.mosi),
    .dc_i         (bus.dc),
    .lcd_clk_i    (bus.lcd_clk),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .dc_o         (rx_dc),
    .error_o      (rx_error)
  );

  dec_state_e  state_q;
  logic [1:0]  pidx_q;
  logic [7:0]  xs_q, xe_q, ys_q, ye_q, cx_q, cy_q, hi_q;
  logic        cmd_valid_q, pix_valid_q, disp_on_q;
  logic [7:0]  cmd_byte_q, pix_x_q, pix_y_q;
  logic [15:0] pix_data_q;
`ifdef ST7735_RX_FRAME_CNT_EN
  logic        frame_done_q;
  logic [15:0] frame_cnt_q;
`endif

  logic win_ok, in_bounds, at_end;
  assign win_ok    = (xs_q <= xe_q) && (ys_q <= ye_q);
  assign in_bounds = ({1'b0, cx_q} < W_LIM) && ({1'b0, cy_q} < H_LIM);
  assign at_end    = (cx_q == xe_q) && (cy_q == ye_q);

  // Command dispatch, parameter collection and pixel assembly.
  always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      pidx_q      <= 2'd0;
      xs_q        <= 8'd0;
      xe_q        <= XE_DEF;
      ys_q        <= 8'd0;
      ye_q        <= YE_DEF;
      cx_q        <= 8'd0;
      cy_q        <= 8'd0;
      hi_q        <= 8'd0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'd0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= 8'd0;
      pix_y_q     <= 8'd0;
      pix_data_q  <= 16'd0;
      disp_on_q   <= 1'b0;
`ifdef ST7735_RX_FRAME_CNT_EN
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
`endif
    end else begin
      cmd_valid_q <= 1'b0;
      pix_valid_q <= 1'b0;
`ifdef ST7735_RX_FRAME_CNT_EN
      frame_done_q <= 1'b0;
`endif
      if (rx_valid) begin
        if (!rx_dc) begin
          cmd_valid_q <= 1'b1;
          cmd_byte_q  <= rx_byte;
          pidx_q      <= 2'd0;
          case (rx_byte)
            OP_CASET:   state_q <= ST_CASET_P;
            OP_RASET:   state_q <= ST_RASET_P;
            OP_RAMWR: begin
              state_q <= ST_RAMWR_HI;
              cx_q    <= xs_q;
              cy_q    <= ys_q;
            end
            OP_DISPON: begin
              disp_on_q <= 1'b1;
              state_q   <= ST_IDLE;
            end
            OP_DISPOFF: begin
              disp_on_q <= 1'b0;
              state_q   <= ST_IDLE;
            end
            OP_SWRESET: begin
              xs_q      <= 8'd0;
              xe_q      <= XE_DEF;
              ys_q      <= 8'd0;
              ye_q      <= YE_DEF;
              disp_on_q <= 1'b0;
              state_q   <= ST_IDLE;
            end
            OP_SLPOUT:  state_q <= ST_IDLE;
            default:    state_q <= ST_IGNORE;
          endcase
        end else begin
          case (state_q)
            ST_CASET_P: begin
              pidx_q <= pidx_q + 2'd1;
              if (pidx_q == 2'd1) xs_q <= rx_byte;
              if (pidx_q == 2'd3) begin
                xe_q    <= rx_byte;
                state_q <= ST_IDLE;
              end
            end
            ST_RASET_P: begin
              pidx_q <= pidx_q + 2'd1;
              if (pidx_q == 2'd1) ys_q <= rx_byte;
              if (pidx_q == 2'd3) begin
                ye_q    <= rx_byte;
                state_q <= ST_IDLE;
              end
            end
            ST_RAMWR_HI: begin
              hi_q    <= rx_byte;
              state_q <= ST_RAMWR_LO;
            end
            ST_RAMWR_LO: begin
              state_q <= ST_RAMWR_HI;
              // An inverted window swallows pixel bytes and freezes the cursor.
              if (win_ok) begin
                if (in_bounds) begin
                  pix_valid_q <= 1'b1;
                  pix_x_q     <= cx_q;
                  pix_y_q     <= cy_q;
                  pix_data_q  <= {hi_q, rx_byte};
`ifdef ST7735_RX_FRAME_CNT_EN
                  if (at_end) begin
                    frame_done_q <= 1'b1;
                    frame_cnt_q  <= frame_cnt_q + 16'd1;
                  end
`endif
                end
                if (cx_q == xe_q) begin
                  cx_q <= xs_q;
                  cy_q <= (cy_q == ye_q) ? ys_q : cy_q + 8'd1;
                end else begin
                  cx_q <= cx_q + 8'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_byte    = cmd_byte_q;
  assign bus.pixel_valid = pix_valid_q;
  assign bus.pixel_x     = pix_x_q;
  assign bus.pixel_y     = pix_y_q;
  assign bus.pixel_data  = pix_data_q;
  assign bus.display_on  = disp_on_q;
  assign bus.error       = rx_error;
`ifdef ST7735_RX_FRAME_CNT_EN
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_count = frame_cnt_q;
`else
  // at_end only drives the frame counter
  logic unused_at_end;
  assign unused_at_end = at_end;
`endif

endmodule
